// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, control word layout,
// branch-select encodings and the function-select lookup.
package isa_pkg;

  localparam int OPC_W = 7;
  localparam int RA_W  = 5;
  localparam int FS_W  = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 7'h00,
    OP_ADD = 7'h02,
    OP_SUB = 7'h05,
    OP_AND = 7'h08,
    OP_OR  = 7'h09,
    OP_XOR = 7'h0A,
    OP_NOT = 7'h0B,
    OP_MOV = 7'h0C,
    OP_LSR = 7'h0D,
    OP_LSL = 7'h0E,
    OP_LD  = 7'h10,
    OP_ST  = 7'h20,
    OP_JML = 7'h30,
    OP_ADI = 7'h42,
    OP_JMP = 7'h44,
    OP_SBI = 7'h45,
    OP_ANI = 7'h48,
    OP_ORI = 7'h49,
    OP_XRI = 7'h4A,
    OP_BZ  = 7'h60,
    OP_BNZ = 7'h61,
    OP_AIU = 7'h62,
    OP_SIU = 7'h65,
    OP_JMR = 7'h70
  } opcode_e;

  localparam logic [1:0] BS_NONE = 2'd0;
  localparam logic [1:0] BS_COND = 2'd1;
  localparam logic [1:0] BS_JUMP = 2'd2;
  localparam logic [1:0] BS_JREG = 2'd3;

  typedef struct packed {
    logic            rw;
    logic [RA_W-1:0] da;
    logic            md;
    logic [1:0]      bs;
    logic            ps;
    logic            mw;
    logic [FS_W-1:0] fs;
    logic [4:0]      sh;
    logic            ma;
    logic            mb;
    logic [RA_W-1:0] aa;
    logic [RA_W-1:0] ba;
    logic            cs;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // ALU function select per opcode; branches, memory ops and jumps pass A through
  function automatic logic [FS_W-1:0] fs_of(input logic [OPC_W-1:0] op);
    logic [FS_W-1:0] fs;
    case (op)
      OP_ADD, OP_ADI, OP_AIU: fs = 5'b00010;
      OP_SUB, OP_SBI, OP_SIU: fs = 5'b00101;
      OP_AND, OP_ANI:         fs = 5'b01000;
      OP_OR,  OP_ORI:         fs = 5'b01010;
      OP_XOR, OP_XRI:         fs = 5'b01100;
      OP_NOT:                 fs = 5'b01110;
      OP_LSR:                 fs = 5'b10100;
      OP_LSL:                 fs = 5'b11000;
      default:                fs = 5'b00000;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decode.sv
// Combinational instruction decoder: instruction word to control word,
// extended immediate and register-read flags used by the hazard compare.
module instr_decode
  import isa_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic [DATA_W-1:0]  imm,
  output logic               reads_a,
  output logic               reads_b
);

  logic [OPC_W-1:0]  op_s;
  logic [REG_AW-1:0] da_s;
  logic [REG_AW-1:0] aa_s;
  logic [REG_AW-1:0] ba_s;
  ctrl_t             ctrl_s;
  logic              reads_a_s;
  logic              reads_b_s;

  assign op_s = instr[31:25];
  assign da_s = instr[20 +: REG_AW];
  assign aa_s = instr[15 +: REG_AW];
  assign ba_s = instr[10 +: REG_AW];

  // Per-class control decode; NOP and unknown opcodes share the all-disabled default
  always_comb begin
    ctrl_s    = '0;
    ctrl_s.da = da_s;
    ctrl_s.aa = aa_s;
    ctrl_s.ba = ba_s;
    ctrl_s.sh = instr[4:0];
    ctrl_s.fs = fs_of(op_s);
    reads_a_s = 1'b0;
    reads_b_s = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl_s.rw = 1'b1;
        reads_a_s = 1'b1;
        reads_b_s = 1'b1;
      end
      OP_NOT, OP_MOV, OP_LSL, OP_LSR: begin
        ctrl_s.rw = 1'b1;
        reads_a_s = 1'b1;
      end
      OP_LD: begin
        ctrl_s.rw = 1'b1;
        ctrl_s.md = 1'b1;
        reads_a_s = 1'b1;
        reads_b_s = 1'b1;
      end
      OP_ST: begin
        ctrl_s.mw = 1'b1;
        reads_a_s = 1'b1;
        reads_b_s = 1'b1;
      end
      OP_ADI, OP_SBI: begin
        ctrl_s.rw = 1'b1;
        ctrl_s.mb = 1'b1;
        ctrl_s.cs = 1'b1;
        reads_a_s = 1'b1;
      end
      OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU: begin
        ctrl_s.rw = 1'b1;
        ctrl_s.mb = 1'b1;
        reads_a_s = 1'b1;
      end
      OP_BZ: begin
        ctrl_s.bs = BS_COND;
        ctrl_s.ps = 1'b1;
        ctrl_s.mb = 1'b1;
        ctrl_s.cs = 1'b1;
      end
      OP_BNZ: begin
        ctrl_s.bs = BS_COND;
        ctrl_s.mb = 1'b1;
        ctrl_s.cs = 1'b1;
      end
      OP_JMP: begin
        ctrl_s.bs = BS_JUMP;
        ctrl_s.mb = 1'b1;
        ctrl_s.cs = 1'b1;
      end
      OP_JML: begin
        ctrl_s.rw = 1'b1;
        ctrl_s.bs = BS_JUMP;
        ctrl_s.ma = 1'b1;
        ctrl_s.mb = 1'b1;
        ctrl_s.cs = 1'b1;
      end
      OP_JMR: begin
        ctrl_s.bs = BS_JREG;
        reads_a_s = 1'b1;
      end
      default: begin
        ctrl_s.rw = 1'b0;
      end
    endcase
  end

  // Immediate extension follows the constant-select bit
  always_comb begin
    if (ctrl_s.cs) begin
      imm = {{(DATA_W-15){instr[14]}}, instr[14:0]};
    end else begin
      imm = {{(DATA_W-15){1'b0}}, instr[14:0]};
    end
  end

  assign ctrl    = ctrl_s;
  assign reads_a = reads_a_s;
  assign reads_b = reads_b_s;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: ID/EX pipeline register with valid/ready handshake,
// load-use bubble insertion, EX flush and a saturating bubble counter.
module decode_stage
  import isa_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [PC_W-1:0]    ex_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t             dec_ctrl_s;
  logic [DATA_W-1:0] dec_imm_s;
  logic              dec_reads_a_s;
  logic              dec_reads_b_s;

  ctrl_t             ctrl_r;
  logic [DATA_W-1:0] imm_r;
  logic [PC_W-1:0]   pc_r;
  logic              valid_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              held_ld_s;
  logic              hazard_s;
  logic              ready_s;
  logic              accept_s;
  logic              bubble_s;

  instr_decode #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW)
  ) u_decode (
    .instr   (if_instr),
    .ctrl    (dec_ctrl_s),
    .imm     (dec_imm_s),
    .reads_a (dec_reads_a_s),
    .reads_b (dec_reads_b_s)
  );

  // Load-use compare against the held instruction and handshake qualification
  always_comb begin
    held_ld_s = valid_r && ctrl_r.md && ctrl_r.rw && (ctrl_r.da != {RA_W{1'b0}});
    hazard_s  = held_ld_s &&
                ((dec_reads_a_s && (dec_ctrl_s.aa == ctrl_r.da)) ||
                 (dec_reads_b_s && (dec_ctrl_s.ba == ctrl_r.da)));
    ready_s   = !flush && !hazard_s && (!valid_r || ex_ready);
    accept_s  = if_valid && ready_s;
    bubble_s  = !flush && hazard_s && ex_ready && if_valid;
  end

  // ID/EX register: flush beats acceptance; a consumed slot with no new word drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      imm_r   <= '0;
      pc_r    <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      ctrl_r  <= dec_ctrl_s;
      imm_r   <= dec_imm_s;
      pc_r    <= if_pc;
    end else if (ex_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Saturating count of inserted load-use bubbles; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (bubble_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign if_ready  = ready_s;
  assign ex_valid  = valid_r;
  assign ex_ctrl   = ctrl_r;
  assign ex_imm    = imm_r;
  assign ex_pc     = pc_r;
  assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
  import isa_pkg::*;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               ex_valid;
  logic               ex_ready;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [DATA_W-1:0]  ex_imm;
  logic [PC_W-1:0]    ex_pc;
  logic [CNT_W-1:0]   stall_cnt;
  ctrl_t              c;

  int checks = 0;
  int errors = 0;

  assign c = ctrl_t'(ex_ctrl);

  always #5 clk = ~clk;

  decode_stage #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_ctrl   (ex_ctrl),
    .ex_imm    (ex_imm),
    .ex_pc     (ex_pc),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [31:0] rr(input logic [6:0] op, input logic [4:0] da,
                                     input logic [4:0] aa, input logic [4:0] ba);
    return {op, da, aa, ba, 10'd0};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] da,
                                     input logic [4:0] aa, input logic [14:0] low);
    return {op, da, aa, low};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = i;
    if_pc    = pc;
  endtask

  task automatic idle();
    if_valid = 1'b0;
    if_instr = 32'd0;
    if_pc    = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1; idle();
    #12;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
    checks++; if (ex_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %0h want 0", ex_ctrl); end
    checks++; if (ex_imm !== 32'd0) begin errors++; $display("FAIL reset_imm: got %0h want 0", ex_imm); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", ex_pc); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", stall_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    put(rr(OP_ADD, 5'd5, 5'd3, 5'd1), 32'h100);
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %0h want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0h want 1", ex_valid); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL add_pc: got %0h want 100", ex_pc); end
    checks++; if (c.rw !== 1'b1 || c.da !== 5'd5 || c.aa !== 5'd3 || c.ba !== 5'd1) begin errors++; $display("FAIL add_fields: got rw=%0h da=%0d aa=%0d ba=%0d want 1 5 3 1", c.rw, c.da, c.aa, c.ba); end
    checks++; if (c.fs !== 5'b00010 || c.cs !== 1'b0 || c.mb !== 1'b0) begin errors++; $display("FAIL add_fs: got fs=%0b cs=%0h mb=%0h want 00010 0 0", c.fs, c.cs, c.mb); end
    checks++; if (ex_imm !== 32'h0000_0400) begin errors++; $display("FAIL add_imm: got %0h want 400", ex_imm); end
    put(mk(OP_ADI, 5'd2, 5'd1, 15'h7FFF), 32'h104);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104) begin errors++; $display("FAIL adi_pc: got v=%0h pc=%0h want 1 104", ex_valid, ex_pc); end
    checks++; if (ex_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL adi_imm: got %0h want ffffffff", ex_imm); end
    checks++; if (c.cs !== 1'b1 || c.mb !== 1'b1 || c.ma !== 1'b0) begin errors++; $display("FAIL adi_class: got cs=%0h mb=%0h ma=%0h want 1 1 0", c.cs, c.mb, c.ma); end
    put(mk(OP_ANI, 5'd4, 5'd1, 15'h7FFF), 32'h108);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h108) begin errors++; $display("FAIL ani_pc: got v=%0h pc=%0h want 1 108", ex_valid, ex_pc); end
    checks++; if (ex_imm !== 32'h0000_7FFF) begin errors++; $display("FAIL ani_imm: got %0h want 7fff", ex_imm); end
    checks++; if (c.cs !== 1'b0 || c.mb !== 1'b1 || c.fs !== 5'b01000) begin errors++; $display("FAIL ani_class: got cs=%0h mb=%0h fs=%0b want 0 1 01000", c.cs, c.mb, c.fs); end
    idle();
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0h want 0", ex_valid); end
  endtask

  task automatic test_load_use();
    put(rr(OP_LD, 5'd3, 5'd2, 5'd0), 32'h200);
    tick();
    checks++; if (ex_valid !== 1'b1 || c.md !== 1'b1 || c.rw !== 1'b1) begin errors++; $display("FAIL ld_held: got v=%0h md=%0h rw=%0h want 1 1 1", ex_valid, c.md, c.rw); end
    put(rr(OP_ADD, 5'd5, 5'd3, 5'd1), 32'h204);
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_low: got %0h want 0", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0h want 0", ex_valid); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_back: got %0h want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin errors++; $display("FAIL lu_dep: got v=%0h pc=%0h want 1 204", ex_valid, ex_pc); end
    idle();
    tick();
  endtask

  task automatic test_no_hazard();
    put(rr(OP_LD, 5'd0, 5'd2, 5'd0), 32'h300);
    tick();
    put(rr(OP_ADD, 5'd5, 5'd0, 5'd1), 32'h304);
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %0h want 1", if_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h304) begin errors++; $display("FAIL r0_accept: got v=%0h pc=%0h want 1 304", ex_valid, ex_pc); end
    put(rr(OP_LD, 5'd3, 5'd2, 5'd0), 32'h308);
    tick();
    put(mk(OP_ADI, 5'd4, 5'd1, {5'd3, 10'd0}), 32'h30C);
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL mb_ready: got %0h want 1", if_ready); end
    tick();
    checks++; if (ex_pc !== 32'h30C || ex_imm !== 32'h0000_0C00) begin errors++; $display("FAIL mb_accept: got pc=%0h imm=%0h want 30c c00", ex_pc, ex_imm); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL nohaz_cnt: got %0d want 1", stall_cnt); end
    put(rr(7'h7F, 5'd6, 5'd3, 5'd1), 32'h310);
    tick();
    checks++; if (ex_valid !== 1'b1 || c.rw !== 1'b0 || c.mw !== 1'b0 || c.bs !== 2'd0 || c.fs !== 5'd0) begin errors++; $display("FAIL unknown_op: got v=%0h rw=%0h mw=%0h bs=%0d fs=%0b want 1 0 0 0 0", ex_valid, c.rw, c.mw, c.bs, c.fs); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    put(rr(OP_ADD, 5'd7, 5'd1, 5'd2), 32'h400);
    tick();
    ex_ready = 1'b0;
    put(rr(OP_SUB, 5'd8, 5'd7, 5'd1), 32'h404);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0h want 0", k, if_ready); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || c.da !== 5'd7) begin errors++; $display("FAIL bp_hold[%0d]: got v=%0h pc=%0h da=%0d want 1 400 7", k, ex_valid, ex_pc, c.da); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0h want 1", if_ready); end
    tick();
    checks++; if (ex_pc !== 32'h404 || c.fs !== 5'b00101) begin errors++; $display("FAIL bp_next: got pc=%0h fs=%0b want 404 00101", ex_pc, c.fs); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    put(mk(OP_JMP, 5'd0, 5'd0, 15'h0010), 32'h500);
    tick();
    checks++; if (c.bs !== 2'd2 || c.rw !== 1'b0) begin errors++; $display("FAIL jmp_decode: got bs=%0d rw=%0h want 2 0", c.bs, c.rw); end
    put(mk(OP_JML, 5'd1, 5'd0, 15'h0020), 32'h504);
    flush = 1'b1;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0h want 0", if_ready); end
    tick();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h500) begin errors++; $display("FAIL flush_kill: got v=%0h pc=%0h want 0 500", ex_valid, ex_pc); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", stall_cnt); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h504) begin errors++; $display("FAIL jml_accept: got v=%0h pc=%0h want 1 504", ex_valid, ex_pc); end
    checks++; if (c.ma !== 1'b1 || c.mb !== 1'b1 || c.cs !== 1'b1 || c.bs !== 2'd2 || c.rw !== 1'b1) begin errors++; $display("FAIL jml_decode: got ma=%0h mb=%0h cs=%0h bs=%0d rw=%0h want 1 1 1 2 1", c.ma, c.mb, c.cs, c.bs, c.rw); end
    idle();
    ex_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex_ready = 1'b1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_over_hold: got %0h want 0", ex_valid); end
  endtask

  task automatic test_async_reset();
    put(rr(OP_LD, 5'd3, 5'd2, 5'd0), 32'h600);
    tick();
    ex_ready = 1'b0;
    put(rr(OP_ADD, 5'd5, 5'd3, 5'd1), 32'h604);
    tick();
    checks++; if (ex_valid !== 1'b1 || if_ready !== 1'b0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_hold: got v=%0h rdy=%0h cnt=%0d want 1 0 1", ex_valid, if_ready, stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL async_reset: got v=%0h cnt=%0d want 0 0", ex_valid, stall_cnt); end
    checks++; if (ex_ctrl !== '0 || ex_pc !== 32'd0) begin errors++; $display("FAIL async_reset_regs: got ctrl=%0h pc=%0h want 0 0", ex_ctrl, ex_pc); end
    #2;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h604) begin errors++; $display("FAIL post_reset_accept: got v=%0h pc=%0h want 1 604", ex_valid, ex_pc); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_hazard();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
